// File: rtl/branch_predictor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor_pkg
// Description : Shared constants for the branch predictor: default widths,
//               prediction-mode encodings, 2-bit counter states and the
//               operation codes understood by sat_counter2.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_predictor_pkg;

   localparam int DEFAULT_WORD_SIZE  = 16;
   localparam int DEFAULT_INDEX_BITS = 4;

   // Prediction mode encodings
   localparam int BP_BIMODAL   = 0;
   localparam int BP_STATIC_NT = 1;
   localparam int BP_BTB_ONLY  = 2;

   // 2-bit direction counter states
   localparam logic [1:0] CNT_SNT = 2'd0;  // strongly not taken
   localparam logic [1:0] CNT_WNT = 2'd1;  // weakly not taken
   localparam logic [1:0] CNT_WT  = 2'd2;  // weakly taken
   localparam logic [1:0] CNT_ST  = 2'd3;  // strongly taken

   // Operations applied to a single entry counter in one cycle
   typedef enum logic [1:0] {
      CNT_HOLD = 2'd0,
      CNT_INC  = 2'd1,
      CNT_DEC  = 2'd2,
      CNT_LOAD = 2'd3
   } cnt_op_e;

endpackage
`default_nettype wire

// File: rtl/branch_predictor_sat_counter2.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter2
// Description : 2-bit saturating up/down counter with synchronous load.
//               Ports:
//                 clk      - clock, rising edge
//                 reset_n  - asynchronous active-low reset (to RESET_VAL)
//                 op       - CNT_HOLD / CNT_INC / CNT_DEC / CNT_LOAD
//                 load_val - value taken on CNT_LOAD
//                 count    - current counter value
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter2
   import branch_predictor_pkg::*;
#(
   parameter logic [1:0] RESET_VAL = CNT_WT
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] op,
   input  logic [1:0] load_val,
   output logic [1:0] count
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= RESET_VAL;
      end else begin
         case (op)
            CNT_INC:  if (count != CNT_ST)  count <= count + 2'd1;
            CNT_DEC:  if (count != CNT_SNT) count <= count - 2'd1;
            CNT_LOAD: count <= load_val;
            default:  count <= count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped, tagged branch target buffer with per-entry
//               2-bit direction counters and a selectable prediction mode.
//               Lookup is combinational from the fetch PC; updates from the
//               resolving stage are registered. Saturating statistics.
//               Ports:
//                 clk, reset_n                 - clock / async active-low reset
//                 lookup_valid, lookup_pc      - fetch request
//                 pred_taken, pred_target,
//                 pred_next_pc                 - prediction (combinational)
//                 update_valid, update_pc,
//                 update_taken, update_target,
//                 update_is_cond,
//                 update_mispredict            - resolved control instruction
//                 flush_all                    - invalidate whole table
//                 stat_lookups, stat_hits,
//                 stat_mispredicts             - saturating statistics
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int         WORD_SIZE  = DEFAULT_WORD_SIZE,
   parameter int         INDEX_BITS = DEFAULT_INDEX_BITS,
   parameter int         MODE       = BP_BIMODAL,
   parameter logic [1:0] CNT_INIT   = 2'b10
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 lookup_valid,
   input  logic [WORD_SIZE-1:0] lookup_pc,
   output logic                 pred_taken,
   output logic [WORD_SIZE-1:0] pred_target,
   output logic [WORD_SIZE-1:0] pred_next_pc,
   input  logic                 update_valid,
   input  logic [WORD_SIZE-1:0] update_pc,
   input  logic                 update_taken,
   input  logic [WORD_SIZE-1:0] update_target,
   input  logic                 update_is_cond,
   input  logic                 update_mispredict,
   input  logic                 flush_all,
   output logic [WORD_SIZE-1:0] stat_lookups,
   output logic [WORD_SIZE-1:0] stat_hits,
   output logic [WORD_SIZE-1:0] stat_mispredicts
);

   localparam int ENTRIES  = 1 << INDEX_BITS;
   localparam int TAG_BITS = WORD_SIZE - INDEX_BITS;
   localparam logic [WORD_SIZE-1:0] ONE = {{(WORD_SIZE-1){1'b0}}, 1'b1};

   // ------------------------------------------------------------------------
   // Table storage
   // ------------------------------------------------------------------------
   logic [ENTRIES-1:0]   valid;
   logic [TAG_BITS-1:0]  tag_mem    [ENTRIES];
   logic [WORD_SIZE-1:0] target_mem [ENTRIES];
   logic [1:0]           cnt        [ENTRIES];

   // ------------------------------------------------------------------------
   // Lookup path (combinational, reads pre-update contents: no bypass)
   // ------------------------------------------------------------------------
   logic [INDEX_BITS-1:0] lk_idx;
   logic [TAG_BITS-1:0]   lk_tag;
   logic                  hit;

   assign lk_idx = lookup_pc[INDEX_BITS-1:0];
   assign lk_tag = lookup_pc[WORD_SIZE-1:INDEX_BITS];
   assign hit    = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);

   always_comb begin
      pred_taken = 1'b0;
      case (MODE)
         BP_STATIC_NT: pred_taken = 1'b0;
         BP_BTB_ONLY:  pred_taken = hit;
         default:      pred_taken = hit && cnt[lk_idx][1];
      endcase
   end

   assign pred_target  = hit ? target_mem[lk_idx] : '0;
   assign pred_next_pc = pred_taken ? pred_target : (lookup_pc + ONE);

   // ------------------------------------------------------------------------
   // Update decode
   // ------------------------------------------------------------------------
   logic [INDEX_BITS-1:0] up_idx;
   logic [TAG_BITS-1:0]   up_tag;
   logic                  up_hit;
   logic                  do_update;   // flush_all drops the update
   logic                  alloc;
   logic                  wr_target;
   cnt_op_e               cnt_op;
   logic [1:0]            cnt_load;

   assign up_idx    = update_pc[INDEX_BITS-1:0];
   assign up_tag    = update_pc[WORD_SIZE-1:INDEX_BITS];
   assign up_hit    = valid[up_idx] && (tag_mem[up_idx] == up_tag);
   assign do_update = update_valid && !flush_all;
   assign alloc     = do_update && !up_hit && update_taken;
   // A not-taken conditional hit keeps its old target; everything else
   // that touches the table rewrites it.
   assign wr_target = do_update &&
                      (up_hit ? (!update_is_cond || update_taken) : update_taken);

   always_comb begin
      cnt_op   = CNT_HOLD;
      cnt_load = CNT_ST;
      if (do_update) begin
         if (up_hit) begin
            if (update_is_cond) cnt_op = update_taken ? CNT_INC : CNT_DEC;
            else                cnt_op = CNT_LOAD;
         end else if (update_taken) begin
            cnt_op   = CNT_LOAD;
            cnt_load = update_is_cond ? CNT_INIT : CNT_ST;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Per-entry direction counters
   // ------------------------------------------------------------------------
   for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
      logic [1:0] entry_op;
      assign entry_op = (up_idx == INDEX_BITS'(i)) ? cnt_op : CNT_HOLD;

      sat_counter2 #(
         .RESET_VAL (CNT_INIT)
      ) u_cnt (
         .clk      (clk),
         .reset_n  (reset_n),
         .op       (entry_op),
         .load_val (cnt_load),
         .count    (cnt[i])
      );
   end

   // ------------------------------------------------------------------------
   // Valid / tag / target storage
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_mem[i]    <= '0;
            target_mem[i] <= '0;
         end
      end else begin
         if (flush_all) begin
            valid <= '0;
         end else if (alloc) begin
            valid[up_idx]   <= 1'b1;
            tag_mem[up_idx] <= up_tag;
         end
         if (wr_target) target_mem[up_idx] <= update_target;
      end
   end

   // ------------------------------------------------------------------------
   // Statistics, saturating at all ones
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stat_lookups     <= '0;
         stat_hits        <= '0;
         stat_mispredicts <= '0;
      end else begin
         if (lookup_valid && (stat_lookups != '1))
            stat_lookups <= stat_lookups + ONE;
         if (lookup_valid && hit && (stat_hits != '1))
            stat_hits <= stat_hits + ONE;
         // Counted even when flush_all drops the update itself
         if (update_valid && update_mispredict && (stat_mispredicts != '1))
            stat_mispredicts <= stat_mispredicts + ONE;
      end
   end

endmodule
`default_nettype wire
